// File: rtl/attention_pkg.sv
// Shared types and beat-order constants for the attention job sequencer.
// Matrix elements are carried as 32-bit Q16.16 fixed-point words, the
// synthesizable stand-in for the real-valued operands of the attention array.
package attention_pkg;

  localparam int ELEM_W = 32;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  // Host beats arrive as Q rows, then K rows, then V rows.
  localparam int Q_BASE = 0;

  function automatic int k_base(input int n);
    return n;
  endfunction

  function automatic int v_base(input int n);
    return 2 * n;
  endfunction

  // Width of a counter that must reach max_val; never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/attention_row_drain.sv
// Result buffer plus row-by-row valid/ready drain of one attention result.
// The buffer is snapshotted on capture, so the array may change its result
// output afterwards without disturbing the rows being handed to the host.
module attention_row_drain
  import attention_pkg::*;
#(
  parameter int N = 4,
  parameter int d = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture,
  input  elem_t [N-1:0][d-1:0]      attention,
  input  logic                      out_ready,
  output logic                      out_valid,
  output elem_t [d-1:0]             out_row,
  output logic [cnt_w(N-1)-1:0]     out_idx,
  output logic                      out_last,
  output logic                      done
);

  localparam int IDX_W = cnt_w(N - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  elem_t [N-1:0][d-1:0] buffer;

  // Snapshot the array result when the job completes.
  // NOTE: the buffer is reset even though it is data storage, because the
  // outputs must read back as zero after reset and out_row is a direct view.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buffer <= '0;
    end else if (capture) begin
      buffer <= attention;
    end
  end

  // Row pointer and valid flag: valid rises on capture, drops only after the
  // handshake on the last row, so a started drain is never withdrawn.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_idx   <= '0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_idx   <= '0;
      end else begin
        out_idx <= out_idx + 1'b1;
      end
    end
  end

  assign out_last = out_valid && (out_idx == LAST_IDX);
  assign out_row  = buffer[out_idx];
  assign done     = out_valid && out_ready && out_last;

endmodule

// File: rtl/attention_job_sequencer.sv
// Job sequencer in front of an attention array: collects Q, K and V row by
// row from the host, starts the array with a one-cycle pulse, waits for the
// result (with a timeout), then streams the result rows back to the host.
module attention_job_sequencer
  import attention_pkg::*;
#(
  parameter int N           = 4,
  parameter int d           = 4,
  parameter int INIT_CYCLES = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  elem_t [d-1:0]             in_row,
  output elem_t [N-1:0][d-1:0]      Q_matrix,
  output elem_t [N-1:0][d-1:0]      K_matrix,
  output elem_t [N-1:0][d-1:0]      V_matrix,
  output logic                      valid_input,
  input  elem_t [N-1:0][d-1:0]      attention,
  input  logic                      valid_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output elem_t [d-1:0]             out_row,
  output logic [cnt_w(N-1)-1:0]     out_idx,
  output logic                      out_last,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W  = cnt_w(N - 1);
  localparam int BEAT_W = cnt_w(3 * N);
  localparam int WAIT_W = cnt_w(TIMEOUT);
  localparam int INIT_W = cnt_w(INIT_CYCLES);

  localparam logic [BEAT_W-1:0] Q_ROW     = BEAT_W'(Q_BASE);
  localparam logic [BEAT_W-1:0] K_ROW     = BEAT_W'(k_base(N));
  localparam logic [BEAT_W-1:0] V_ROW     = BEAT_W'(v_base(N));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(3 * N - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(3 * N);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [INIT_W-1:0] LAST_INIT = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_MAX  = INIT_W'(INIT_CYCLES);

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]    row_idx;
  logic                in_fire;
  logic                capture;
  logic                timeout_hit;
  logic                drain_done;

  assign in_fire     = in_valid && in_ready;
  assign capture     = (state_q == ST_WAIT) && valid_result;
  assign timeout_hit = (state_q == ST_WAIT) && !valid_result && (wait_cnt == LAST_WAIT);
  assign busy        = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    valid_input = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt == LAST_INIT) state_d = ST_IDLE;
      end
      ST_IDLE, ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (beat_cnt == LAST_BEAT) ? ST_ISSUE : ST_LOAD;
        end
      end
      ST_ISSUE: begin
        valid_input = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (valid_result)   state_d = ST_DRAIN;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Power-up settling counter; saturates once the array is ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt <= '0;
    end else if (state_q == ST_INIT && init_cnt != INIT_MAX) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Beat counter: addresses the next matrix row, restarts once a job issues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (state_q == ST_ISSUE) begin
      beat_cnt <= '0;
    end else if (in_fire && beat_cnt != BEAT_MAX) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Wait counter: cycles spent in WAIT without a result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_q != ST_WAIT) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky abort flag: set on timeout, cleared by the next job's first beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end else if (state_q == ST_IDLE && in_fire) begin
      timeout_err <= 1'b0;
    end
  end

  // Row within the Q, K or V block that the current beat lands in.
  always_comb begin
    row_idx = IDX_W'(beat_cnt - Q_ROW);
    if (beat_cnt >= V_ROW)      row_idx = IDX_W'(beat_cnt - V_ROW);
    else if (beat_cnt >= K_ROW) row_idx = IDX_W'(beat_cnt - K_ROW);
  end

  // Operand registers: written only by accepted beats, so they stay frozen
  // while the array works on them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q_matrix <= '0;
      K_matrix <= '0;
      V_matrix <= '0;
    end else if (in_fire) begin
      if (beat_cnt >= V_ROW)      V_matrix[row_idx] <= in_row;
      else if (beat_cnt >= K_ROW) K_matrix[row_idx] <= in_row;
      else                        Q_matrix[row_idx] <= in_row;
    end
  end

  attention_row_drain #(
    .N (N),
    .d (d)
  ) u_row_drain (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .attention (attention),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (drain_done)
  );

endmodule

// File: tb/tb_attention_job_sequencer.sv
// Directed bench for the attention job sequencer. The bench keeps its own
// copy of the loaded operands and computes the attention result from them
// with a plain fixed-point model; a negedge monitor compares the DUT against
// that model whenever operands or result rows are meaningful.
module tb_attention_job_sequencer;
  import attention_pkg::*;

  localparam int N           = 4;
  localparam int D           = 4;
  localparam int INIT_CYCLES = 3;
  localparam int TIMEOUT     = 64;

  typedef elem_t [D-1:0]        row_t;
  typedef elem_t [N-1:0][D-1:0] mat_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  row_t         in_row;
  mat_t         Q_matrix, K_matrix, V_matrix;
  logic         valid_input;
  mat_t         attention;
  logic         valid_result;
  logic         out_valid;
  logic         out_ready;
  row_t         out_row;
  logic [$clog2(N)-1:0] out_idx;
  logic         out_last;
  logic         busy;
  logic         timeout_err;

  attention_job_sequencer #(
    .N           (N),
    .d           (D),
    .INIT_CYCLES (INIT_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .Q_matrix     (Q_matrix),
    .K_matrix     (K_matrix),
    .V_matrix     (V_matrix),
    .valid_input  (valid_input),
    .attention    (attention),
    .valid_result (valid_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state.
  mat_t exp_q, exp_k, exp_v, exp_res;
  int   vi_seen, rows_got, last_seen, stall_seen;
  int   stall_row = -1;
  bit   hold_chk = 1'b0;
  bit   drain_armed = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic elem_t fx_mul(input elem_t a, input elem_t b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return elem_t'(p >>> 16);
  endfunction

  // Unnormalised attention (Q * K^T) * V in Q16.16: what the stand-in array returns.
  function automatic mat_t model_attention(input mat_t q, input mat_t k, input mat_t v);
    elem_t [N-1:0][N-1:0] s;
    mat_t a;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s[i][j] = '0;
        for (int c = 0; c < D; c++) s[i][j] += fx_mul(q[i][c], k[j][c]);
      end
    for (int i = 0; i < N; i++)
      for (int c = 0; c < D; c++) begin
        a[i][c] = '0;
        for (int j = 0; j < N; j++) a[i][c] += fx_mul(s[i][j], v[j][c]);
      end
    return a;
  endfunction

  // Q = q_scale * I, K = I, V = I or a ramp (row*D + col + 1).
  task automatic set_job(input int q_scale, input bit ramp_v);
    for (int i = 0; i < N; i++)
      for (int c = 0; c < D; c++) begin
        exp_q[i][c] = (i == c) ? elem_t'(q_scale << 16) : '0;
        exp_k[i][c] = (i == c) ? 32'h0001_0000 : '0;
        if (ramp_v) exp_v[i][c] = elem_t'((i * D + c + 1) << 16);
        else        exp_v[i][c] = (i == c) ? 32'h0001_0000 : '0;
      end
    exp_res = model_attention(exp_q, exp_k, exp_v);
  endtask

  function automatic row_t beat_row(input int b);
    if (b < N)          return exp_q[b];
    else if (b < 2 * N) return exp_k[b - N];
    else                return exp_v[b - 2 * N];
  endfunction

  // Compare process.
  always @(negedge clk) begin
    if (reset) begin
      if (valid_input) vi_seen++;
      if (hold_chk) begin
        for (int r = 0; r < N; r++) begin
          check("hold_q", Q_matrix[r], exp_q[r]);
          check("hold_k", K_matrix[r], exp_k[r]);
          check("hold_v", V_matrix[r], exp_v[r]);
        end
      end
      if (!drain_armed) begin
        check("no_spurious_out", out_valid, 1'b0);
      end else if (out_valid) begin
        if (rows_got < N) begin
          check("out_row", out_row, exp_res[rows_got]);
          check("out_idx", out_idx, rows_got);
          check("out_last", out_last, rows_got == N - 1);
        end else begin
          check("extra_row", out_valid, 1'b0);
        end
        if (out_ready) begin
          if (out_last) last_seen++;
          rows_got++;
        end else if (int'(out_idx) == stall_row) begin
          stall_seen++;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_valid_input"}, valid_input, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
    check({tag, "_out_idx"}, out_idx, '0);
    check({tag, "_out_row"}, out_row, '0);
    for (int r = 0; r < N; r++) begin
      check({tag, "_q"}, Q_matrix[r], '0);
      check({tag, "_k"}, K_matrix[r], '0);
      check({tag, "_v"}, V_matrix[r], '0);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input row_t row);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_row   = row;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("beat_accept_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_and_issue(input int start, input int spur_at);
    for (int b = start; b < 3 * N; b++) begin
      if (b == spur_at) begin
        valid_result = 1'b1;
        attention    = {N*D{32'h0BAD_F00D}};
        @(posedge clk); #1;
        valid_result = 1'b0;
      end
      send_beat(beat_row(b));
    end
    @(negedge clk);
    check("issue_latency", valid_input, 1'b1);
    hold_chk = 1'b1;
  endtask

  task automatic drain(input int s_len);
    int guard, stalled;
    guard = 0;
    stalled = 0;
    while (rows_got < N && guard < 200) begin
      @(posedge clk); #1;
      guard++;
      if (out_valid && int'(out_idx) == stall_row && stalled < s_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready   = 1'b0;
    drain_armed = 1'b0;
  endtask

  task automatic run_job(input int start, input int delay, input int s_row,
                         input int s_len, input int spur_at);
    vi_seen = 0; rows_got = 0; last_seen = 0; stall_seen = 0;
    stall_row = s_row;
    load_and_issue(start, spur_at);
    in_valid = 1'b1;
    in_row   = {D{32'hBAD0_0BAD}};
    repeat (delay) @(negedge clk);
    check("in_ready_while_busy", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    valid_result = 1'b1;
    attention    = exp_res;
    drain_armed  = 1'b1;
    @(posedge clk); #1;
    valid_result = 1'b0;
    attention    = {N*D{32'hDEAD_BEEF}};
    @(negedge clk);
    check("result_latency", out_valid, 1'b1);
    hold_chk = 1'b0;
    drain(s_len);
    @(negedge clk);
    check("job_done_idle", busy, 1'b0);
    check("rows_delivered", rows_got, N);
    check("last_once", last_seen, 1);
    check("valid_input_once", vi_seen, 1);
    if (s_len > 0) check("stall_cycles", stall_seen, s_len);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_row = '0; valid_result = 1'b0;
    attention = '0; out_ready = 1'b0;

    // Pin the model with hand-computed values.
    set_job(2, 1'b1);
    check("model_pin_ramp", exp_res[1][2], 32'h000E_0000);
    check("model_pin_ramp_last", exp_res[3][3], 32'h0020_0000);
    set_job(1, 1'b0);
    check("model_pin_id_diag", exp_res[2][2], 32'h0001_0000);
    check("model_pin_id_off", exp_res[2][1], 32'h0000_0000);

    repeat (3) @(posedge clk); #1;
    check_reset_values("por");

    // Release with in_valid already high: INIT holds off the first beat.
    in_valid = 1'b1;
    in_row   = beat_row(0);
    reset    = 1'b1;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      @(negedge clk);
      check("init_not_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    check("init_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Identity job, 20-cycle array latency, 5-cycle stall on row 1.
    run_job(1, 20, 1, 5, -1);

    // Ramp job with a stray valid_result pulse during LOAD.
    set_job(2, 1'b1);
    run_job(0, 3, -1, 0, 5);

    // Array never answers: timeout.
    set_job(1, 1'b1);
    vi_seen = 0;
    load_and_issue(0, -1);
    repeat (TIMEOUT) @(negedge clk);
    check("timeout_busy_before", busy, 1'b1);
    check("timeout_flag_before", timeout_err, 1'b0);
    @(negedge clk);
    check("timeout_flag", timeout_err, 1'b1);
    check("timeout_idle", busy, 1'b0);
    check("timeout_vi_once", vi_seen, 1);
    hold_chk = 1'b0;
    @(posedge clk); #1;

    // First beat of the next job clears the flag; reset after 7 beats.
    set_job(2, 1'b1);
    send_beat(beat_row(0));
    @(negedge clk);
    check("flag_cleared", timeout_err, 1'b0);
    @(posedge clk); #1;
    for (int b = 1; b < 7; b++) send_beat(beat_row(b));
    reset = 1'b0;
    #1;
    check_reset_values("mid_job");
    @(posedge clk); #1;
    reset = 1'b1;

    // Fresh full job after the abort, stall on the last row.
    run_job(0, 20, 3, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/attention_job_sequencer.md
ATTENTION_JOB_SEQUENCER -- requirements
Module: attention_job_sequencer

Interface
REQ-001 Parameter N, default 4: sequence length, i.e. rows of Q, K, V and the attention result.
REQ-002 Parameter d, default 4: head dimension, i.e. reals per row.
REQ-003 Parameter INIT_CYCLES, default 3: cycles after reset release before the array accepts a job.
REQ-004 Parameter TIMEOUT, default 64: maximum WAIT cycles before a job is aborted.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  host row-beat valid.
REQ-008 in_ready  output  1  sequencer accepts a row beat.
REQ-009 in_row  input  real[0:d-1]  one matrix row.
REQ-010 Q_matrix, K_matrix, V_matrix  output  real[0:N-1][0:d-1]  operands to the attention array.
REQ-011 valid_input  output  1  job-start pulse to the attention array.
REQ-012 attention  input  real[0:N-1][0:d-1]  result from the attention array.
REQ-013 valid_result  input  1  result-complete pulse from the attention array.
REQ-014 out_valid  output  1  result row valid.
REQ-015 out_ready  input  1  host accepts a result row.
REQ-016 out_row  output  real[0:d-1]  one result row.
REQ-017 out_idx  output  $clog2(N)  index of the current result row.
REQ-018 out_last  output  1  high with row N-1.
REQ-019 busy  output  1  state is not IDLE.
REQ-020 timeout_err  output  1  sticky job-abort flag.

Function
REQ-021 FSM states: INIT, IDLE, LOAD, ISSUE, WAIT, DRAIN.
REQ-022 INIT: count INIT_CYCLES cycles, then go to IDLE; in_ready is 0 in INIT.
REQ-023 IDLE/LOAD: in_ready=1; a beat transfers when in_valid and in_ready are both high.
REQ-024 Beat order, 3N beats per job: Q rows 0..N-1, then K rows 0..N-1, then V rows 0..N-1; each beat is written to the matrix register addressed by the beat counter.
REQ-025 First accepted beat in IDLE: clear timeout_err, go to LOAD.
REQ-026 Beat number 3N accepted: go to ISSUE on the next edge.
REQ-027 ISSUE: valid_input=1 for exactly one cycle, then go to WAIT; valid_input=0 in every other state.
REQ-028 Q/K/V_matrix outputs are held stable from ISSUE until the job leaves WAIT.
REQ-029 WAIT: on valid_result=1, snapshot attention into the result buffer and go to DRAIN.
REQ-030 WAIT: after TIMEOUT cycles with no valid_result, set timeout_err and go to IDLE; no output rows are produced.
REQ-031 valid_result in any state other than WAIT is ignored.
REQ-032 DRAIN: out_valid=1, out_row = buffer[out_idx]; out_idx advances on each out_valid&&out_ready handshake.
REQ-033 out_row and out_idx are held while out_ready=0.
REQ-034 Handshake on row N-1 (out_last=1): go to IDLE.
REQ-035 out_valid is never deasserted without a handshake.
REQ-036 in_ready=0 in ISSUE, WAIT and DRAIN; in_valid is ignored in those states.
REQ-037 Counters: beat counter width $clog2(3N+1), wait counter width $clog2(TIMEOUT+1); both saturate, never wrap.
REQ-038 Job latency from the last input beat to valid_input is 1 cycle; from valid_result to out_valid is 1 cycle.

Reset
REQ-039 Reset low forces asynchronously: state=INIT, every counter=0, in_ready=0, valid_input=0, out_valid=0, out_last=0, busy=1 (INIT is not IDLE), timeout_err=0, out_idx=0, every matrix and buffer element=0.0.
REQ-040 Reset asserted mid-job aborts the job with no partial output; after release the sequencer re-enters INIT.

Structure
REQ-041 The state enum and beat-order constants (Q_BASE=0, K_BASE=N, V_BASE=2N) live in shared package attention_pkg.
REQ-042 Result buffering and the row-drain handshake are one sub-module, attention_row_drain; the remainder is the top FSM.

Verification
REQ-043 Release reset, drive in_valid=1 from cycle 0 -> in_ready=0 for 3 cycles, first beat accepted on cycle 3.
REQ-044 Load Q=K=V=identity with N=d=4, model pulses valid_result 20 cycles after valid_input -> exactly one valid_input pulse; 4 result rows equal the model's attention, in order 0..3, out_last only on row 3.
REQ-045 Hold out_ready=0 for 5 cycles on row 1 -> out_row and out_idx=1 stable throughout; row 2 follows only after the handshake.
REQ-046 Model never asserts valid_result -> timeout_err=1 after 64 WAIT cycles; state returns to IDLE; next first beat clears the flag.
REQ-047 Assert reset after 7 of 12 beats -> all outputs at reset values; a fresh 12-beat job then completes correctly.
REQ-048 Pulse valid_result during LOAD -> ignored; the job completes normally on the later pulse.
